// File: rtl/smag_acc_pkg.sv
// smag_acc_pkg
// Shared constants and types for the CiM sign/magnitude accumulation path.
//   DATA_W_DEF / ACC_W_DEF / MAX_TERMS_DEF : default parameter values
//   TERM_CNT_W                             : width able to hold 0..MAX_TERMS
//   state_t                                : controller FSM state encoding
package smag_acc_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ACC_W_DEF     = 20;
    localparam int MAX_TERMS_DEF = 16;
    localparam int TERM_CNT_W    = $clog2(MAX_TERMS_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CONV = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/smag_acc_ctrl_if.sv
// smag_acc_ctrl_if
// Partial-beat input stream plus sign/magnitude result stream.
//   in_valid/in_ready/in_partial/in_sign/in_last : upstream CiM partials
//   out_valid/out_ready/out_magnitude/out_sign/out_sat : downstream result
// Modports: master = upstream/downstream environment, slave = controller.
interface smag_acc_ctrl_if
    import smag_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_partial;
    logic              in_sign;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_magnitude;
    logic              out_sign;
    logic              out_sat;

    modport master (
        output in_valid, in_partial, in_sign, in_last, out_ready,
        input  in_ready, out_valid, out_magnitude, out_sign, out_sat
    );

    modport slave (
        input  in_valid, in_partial, in_sign, in_last, out_ready,
        output in_ready, out_valid, out_magnitude, out_sign, out_sat
    );

endinterface

// File: rtl/smag_conv.sv
// smag_conv
// Combinational two's-complement -> sign/magnitude converter.
//   acc       : ACC_W-bit signed accumulator value
//   sign      : 1 when acc is negative (never set for zero)
//   magnitude : |acc| reduced to DATA_W bits
//   sat       : magnitude was clipped
// Optional build macro SMAG_ACC_SAT_EN: clip to all-ones instead of
// truncating when |acc| does not fit in DATA_W bits.
module smag_conv #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 20
) (
    input  logic [ACC_W-1:0]  acc,
    output logic              sign,
    output logic [DATA_W-1:0] magnitude,
    output logic              sat
);

    logic [ACC_W-1:0] abs_val;

    // Negating the most-negative value yields 2^(ACC_W-1), which is the
    // correct magnitude when abs_val is read as unsigned.
    always_comb begin
        sign    = acc[ACC_W-1];
        abs_val = sign ? (~acc + 1'b1) : acc;
    end

`ifdef SMAG_ACC_SAT_EN
    always_comb begin
        if (|abs_val[ACC_W-1:DATA_W]) begin
            magnitude = {DATA_W{1'b1}};
            sat       = 1'b1;
        end else begin
            magnitude = abs_val[DATA_W-1:0];
            sat       = 1'b0;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^abs_val[ACC_W-1:DATA_W];
    assign magnitude = abs_val[DATA_W-1:0];
    assign sat       = 1'b0;
`endif

endmodule

// File: rtl/smag_acc_ctrl.sv
// smag_acc_ctrl
// Accumulates groups of signed CiM partials and emits each group sum as
// sign/magnitude on a valid/ready result stream.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   bus     : smag_acc_ctrl_if slave (partial input + result output)
//   err_len : sticky, a group reached MAX_TERMS without in_last
//   busy    : controller not in IDLE
// Optional build macro SMAG_ACC_SAT_EN (see smag_conv): saturating magnitude.
//
// state | meaning
// IDLE  | waiting for first beat of a group
// ACC   | accumulating further beats of the group
// CONV  | registering sign/magnitude of the finished sum
// OUT   | result presented, waiting for out_ready
module smag_acc_ctrl
    import smag_acc_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    smag_acc_ctrl_if.slave        bus,
    output logic                  err_len,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [ACC_W-1:0]  term;
    logic [ACC_W-1:0]  zext;
    logic [CNT_W-1:0]  term_cnt, term_cnt_nxt, cnt_inc;
    logic              out_valid_q, out_valid_nxt;
    logic [DATA_W-1:0] out_mag_q, out_mag_nxt;
    logic              out_sign_q, out_sign_nxt;
    logic              out_sat_q, out_sat_nxt;
    logic              err_len_q, err_len_nxt;
    logic              in_ready;
    logic              beat;
    logic              conv_sign;
    logic [DATA_W-1:0] conv_mag;
    logic              conv_sat;

    smag_conv #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_conv (
        .acc       (acc),
        .sign      (conv_sign),
        .magnitude (conv_mag),
        .sat       (conv_sat)
    );

    assign zext    = {{(ACC_W-DATA_W){1'b0}}, bus.in_partial};
    assign term    = bus.in_sign ? (~zext + 1'b1) : zext;
    assign cnt_inc = term_cnt + 1'b1;
    assign beat    = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            term_cnt    <= '0;
            out_valid_q <= 1'b0;
            out_mag_q   <= '0;
            out_sign_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            term_cnt    <= term_cnt_nxt;
            out_valid_q <= out_valid_nxt;
            out_mag_q   <= out_mag_nxt;
            out_sign_q  <= out_sign_nxt;
            out_sat_q   <= out_sat_nxt;
            err_len_q   <= err_len_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        term_cnt_nxt  = term_cnt;
        out_valid_nxt = out_valid_q;
        out_mag_nxt   = out_mag_q;
        out_sign_nxt  = out_sign_q;
        out_sat_nxt   = out_sat_q;
        err_len_nxt   = err_len_q;
        in_ready      = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (beat) begin
                    acc_nxt      = term;
                    term_cnt_nxt = CNT_W'(1);
                    state_nxt    = bus.in_last ? CONV : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (beat) begin
                    acc_nxt      = acc + term;
                    term_cnt_nxt = cnt_inc;
                    if (bus.in_last) begin
                        state_nxt = CONV;
                    end else if (cnt_inc == CNT_W'(MAX_TERMS)) begin
                        // Forced close: the result is still emitted.
                        state_nxt   = CONV;
                        err_len_nxt = 1'b1;
                    end
                end
            end
            CONV: begin
                out_sign_nxt  = conv_sign;
                out_mag_nxt   = conv_mag;
                out_sat_nxt   = conv_sat;
                out_valid_nxt = 1'b1;
                state_nxt     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    acc_nxt       = '0;
                    term_cnt_nxt  = '0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_magnitude = out_mag_q;
    assign bus.out_sign      = out_sign_q;
    assign bus.out_sat       = out_sat_q;
    assign err_len           = err_len_q;
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_smag_acc_ctrl.sv
// tb_smag_acc_ctrl
// Directed bench for smag_acc_ctrl with a result scoreboard.
// Honours SMAG_ACC_SAT_EN to pick the expected magnitude rule.
module tb_smag_acc_ctrl;

    localparam int DATA_W    = 16;
    localparam int ACC_W     = 20;
    localparam int MAX_TERMS = 16;

    typedef struct packed {
        logic [DATA_W-1:0] mag;
        logic              sign;
        logic              sat;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic err_len;
    logic busy;

    smag_acc_ctrl_if #(.DATA_W(DATA_W)) bus ();

    smag_acc_ctrl #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .MAX_TERMS (MAX_TERMS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .err_len (err_len),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_m  = 0;
    int   cnt_m  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wrap_acc(input int v);
        logic [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return int'($signed(t));
    endfunction

    function automatic res_t expect_of(input int a);
        res_t r;
        int   m;
        m      = (a < 0) ? -a : a;
        r.sign = (a < 0);
`ifdef SMAG_ACC_SAT_EN
        if (m > 65535) begin
            r.mag = 16'hFFFF;
            r.sat = 1'b1;
        end else begin
            r.mag = m[DATA_W-1:0];
            r.sat = 1'b0;
        end
`else
        r.mag = m[DATA_W-1:0];
        r.sat = 1'b0;
`endif
        return r;
    endfunction

    task automatic model_beat(input int p, input logic s, input logic l);
        acc_m = wrap_acc(acc_m + (s ? -p : p));
        cnt_m++;
        if (l || cnt_m == MAX_TERMS) begin
            exp_q.push_back(expect_of(acc_m));
            acc_m = 0;
            cnt_m = 0;
        end
    endtask

    task automatic send_beat(input int p, input logic s, input logic l);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.in_partial = p[DATA_W-1:0];
        bus.in_sign    = s;
        bus.in_last    = l;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        end else begin
            @(posedge clk); #1;
            model_beat(p, s, l);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, output int waited);
        res_t e;
        waited = 0;
        while (!bus.out_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_mag"},  {16'd0, bus.out_magnitude}, {16'd0, e.mag});
                check({tag, "_sign"}, {31'd0, bus.out_sign}, {31'd0, e.sign});
                check({tag, "_sat"},  {31'd0, bus.out_sat},  {31'd0, e.sat});
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
        end
    endtask

    initial begin
        int   w;
        res_t e;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_partial = '0;
        bus.in_sign    = 1'b0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_mag",       {16'd0, bus.out_magnitude}, 32'd0);
        check("rst_busy",      {31'd0, busy},    32'd0);
        check("rst_err_len",   {31'd0, err_len}, 32'd0);
        rst = 1'b0;

        // Single negative beat, latency T+2.
        send_beat(5, 1'b1, 1'b1);
        check("single_busy", {31'd0, busy}, 32'd1);
        get_result("single", w);
        check("single_latency", 32'(w), 32'd1);

        // Mixed-sign group, then a one-beat positive group.
        send_beat(100, 1'b0, 1'b0);
        send_beat(30,  1'b1, 1'b0);
        send_beat(80,  1'b1, 1'b1);
        get_result("group", w);
        check("group_latency", 32'(w), 32'd1);
        send_beat(7, 1'b0, 1'b1);
        get_result("plus7", w);

        // Reset mid-group discards the partial sum.
        send_beat(1, 1'b0, 1'b0);
        send_beat(2, 1'b0, 1'b0);
        send_beat(3, 1'b0, 1'b0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_mag",       {16'd0, bus.out_magnitude}, 32'd0);
        check("mid_rst_sign",      {31'd0, bus.out_sign}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy}, 32'd0);
        rst   = 1'b0;
        acc_m = 0;
        cnt_m = 0;
        send_beat(9, 1'b0, 1'b1);
        get_result("after_rst", w);

        // Exact cancellation gives a positive zero.
        send_beat(32'h1234, 1'b0, 1'b0);
        send_beat(32'h1234, 1'b1, 1'b1);
        get_result("cancel", w);

        // Backpressure with a pending upstream beat.
        send_beat(5, 1'b0, 1'b1);
        bus.in_valid   = 1'b1;
        bus.in_partial = 16'd3;
        bus.in_sign    = 1'b0;
        bus.in_last    = 1'b1;
        @(posedge clk); #1;
        check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_mag",   {16'd0, bus.out_magnitude}, {16'd0, e.mag});
            check("bp_in_ready",   {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_drop",      {31'd0, bus.out_valid}, 32'd0);
        check("bp_ready_ret", {31'd0, bus.in_ready},  32'd1);
        @(posedge clk); #1;
        model_beat(3, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("bp_accepted", {31'd0, bus.in_ready}, 32'd0);
        get_result("bp_next", w);
        check("bp_next_latency", 32'(w), 32'd1);

        // Sum exceeding DATA_W but still positive in ACC_W.
        for (int i = 0; i < 8; i++) send_beat(32'hFFFF, 1'b0, (i == 7));
        get_result("ovf", w);

        // Most-negative accumulator value.
        for (int i = 0; i < 8; i++) send_beat(32'hFFFF, 1'b1, 1'b0);
        send_beat(8, 1'b1, 1'b1);
        get_result("most_neg", w);

        // Group forced closed at MAX_TERMS; sum wraps in ACC_W.
        check("err_before", {31'd0, err_len}, 32'd0);
        for (int i = 0; i < MAX_TERMS; i++) send_beat(32'hFFFF, 1'b0, 1'b0);
        check("err_set", {31'd0, err_len}, 32'd1);
        get_result("max_terms", w);
        send_beat(1, 1'b0, 1'b1);
        get_result("post_err", w);
        check("err_sticky", {31'd0, err_len}, 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
